// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order back end: tag widths, the canonical
// NOP, and the reservation-station entry layout with its wakeup helper.
package ooo_pkg;

  localparam int REG_FILE_ADDR_WIDTH = 7;
  localparam int ROB_ADDR_WIDTH      = 5;

  // addi x0, x0, 0 -- what the issue port shows when it has never been loaded.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic                           valid;
    logic [31:0]                    instr;
    logic [31:0]                    pc;
    logic [31:0]                    imm;
    logic [ROB_ADDR_WIDTH-1:0]      rob_tag;
    logic [REG_FILE_ADDR_WIDTH-1:0] prd;
    logic [REG_FILE_ADDR_WIDTH-1:0] prs1;
    logic                           rs1_ready;
    logic [REG_FILE_ADDR_WIDTH-1:0] prs2;
    logic                           rs2_ready;
  } rs_entry_t;

  // Apply one result broadcast to an entry: each source whose tag matches
  // becomes ready. Invalid entries pass through untouched.
  function automatic rs_entry_t wake_entry(
    input rs_entry_t                      e,
    input logic                           cdb_valid,
    input logic [REG_FILE_ADDR_WIDTH-1:0] cdb_tag
  );
    rs_entry_t r;
    r = e;
    if (cdb_valid && e.valid) begin
      if (e.prs1 == cdb_tag) r.rs1_ready = 1'b1;
      if (e.prs2 == cdb_tag) r.rs2_ready = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder: reports whether any request is set and the
// index of the lowest one (entry 0 is the oldest, so lowest index wins).
module rs_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // a combinational output unassigned would infer a latch.
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Compacting reservation station: in-order allocation at the first free slot,
// CDB wakeup of source operands, oldest-ready select into a registered issue
// port with valid/ready handshake. Entry 0 is always the oldest.
// Entry widths come from ooo_pkg; the width parameters must match it.
module reservation_station
  import ooo_pkg::rs_entry_t;
  import ooo_pkg::NOP_INSTR;
  import ooo_pkg::wake_entry;
#(
  parameter int DEPTH               = 4,
  parameter int REG_FILE_ADDR_WIDTH = ooo_pkg::REG_FILE_ADDR_WIDTH,
  parameter int ROB_ADDR_WIDTH      = ooo_pkg::ROB_ADDR_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [31:0]                    disp_instr,
  input  logic [31:0]                    disp_pc,
  input  logic [31:0]                    disp_imm,
  input  logic [ROB_ADDR_WIDTH-1:0]      disp_rob_tag,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] disp_prd,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] disp_prs1,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] disp_prs2,
  input  logic                           disp_rs1_ready,
  input  logic                           disp_rs2_ready,
  input  logic                           cdb_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] cdb_tag,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [31:0]                    issue_instr,
  output logic [31:0]                    issue_pc,
  output logic [31:0]                    issue_imm,
  output logic [ROB_ADDR_WIDTH-1:0]      issue_rob_tag,
  output logic [REG_FILE_ADDR_WIDTH-1:0] issue_prd,
  output logic [REG_FILE_ADDR_WIDTH-1:0] issue_prs1,
  output logic [REG_FILE_ADDR_WIDTH-1:0] issue_prs2,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t        entries     [DEPTH];
  rs_entry_t        woken       [DEPTH];
  rs_entry_t        entries_nxt [DEPTH];
  rs_entry_t        disp_entry;
  rs_entry_t        issue_q;
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    occ_after_issue;
  logic [DEPTH-1:0] ready_vec;
  logic             sel_found;
  logic [SW-1:0]    sel_idx;
  logic             load_issue;
  logic             do_issue;
  logic             disp_fire;
  logic             issue_unused;

  // Handshake qualifiers, all derived from registered state.
  assign disp_ready = (occ_q < CW'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign load_issue = !issue_q.valid || issue_ready;
  assign do_issue   = load_issue && sel_found;

  // Candidates for issue: valid entries with both registered ready bits set.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = entries[i].valid && entries[i].rs1_ready && entries[i].rs2_ready;
    end
  end

  rs_select #(
    .N  (DEPTH),
    .IW (SW)
  ) u_select (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Incoming entry, with a same-cycle CDB match bypassed into its ready bits.
  always_comb begin
    disp_entry           = '0;
    disp_entry.valid     = 1'b1;
    disp_entry.instr     = disp_instr;
    disp_entry.pc        = disp_pc;
    disp_entry.imm       = disp_imm;
    disp_entry.rob_tag   = disp_rob_tag;
    disp_entry.prd       = disp_prd;
    disp_entry.prs1      = disp_prs1;
    disp_entry.rs1_ready = disp_rs1_ready;
    disp_entry.prs2      = disp_prs2;
    disp_entry.rs2_ready = disp_rs2_ready;
    disp_entry           = wake_entry(disp_entry, cdb_valid, cdb_tag);
  end

  // Next array contents: wakeup, then compaction over the issued slot, then
  // allocation at the first free index left after compaction.
  always_comb begin
    occ_after_issue = occ_q - CW'(do_issue);
    for (int i = 0; i < DEPTH; i++) begin
      woken[i]       = wake_entry(entries[i], cdb_valid, cdb_tag);
      entries_nxt[i] = woken[i];
    end
    if (do_issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (SW'(i) >= sel_idx) entries_nxt[i] = woken[i+1];
      end
      entries_nxt[DEPTH-1] = '0;
    end
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == occ_after_issue) entries_nxt[i] = disp_entry;
      end
    end
  end

  // Entry array and occupancy register; flush outranks everything but reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the whole array is reset, not just the valid bits, so no X ever
      // reaches the tag comparators or the issue payload after power-up.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      occ_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
      occ_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples this
      // cycle's values regardless of statement order.
      for (int i = 0; i < DEPTH; i++) entries[i] <= entries_nxt[i];
      occ_q <= occ_after_issue + CW'(disp_fire);
    end
  end

  // Issue register: load the selected entry when empty or accepted, hold
  // otherwise, and drop valid when accepted with nothing to replace it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issue_q       <= '0;
      issue_q.instr <= NOP_INSTR;
    end else if (flush) begin
      issue_q.valid <= 1'b0;
    end else if (do_issue) begin
      issue_q <= entries[sel_idx];
    end else if (issue_ready) begin
      issue_q.valid <= 1'b0;
    end
  end

  assign issue_valid   = issue_q.valid;
  assign issue_instr   = issue_q.instr;
  assign issue_pc      = issue_q.pc;
  assign issue_imm     = issue_q.imm;
  assign issue_rob_tag = issue_q.rob_tag;
  assign issue_prd     = issue_q.prd;
  assign issue_prs1    = issue_q.prs1;
  assign issue_prs2    = issue_q.prs2;
  assign occupancy     = occ_q;

  // Ready bits travel with the issued entry but execute has no use for them.
  assign issue_unused = &{1'b0, issue_q.rs1_ready, issue_q.rs2_ready};

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: table-driven single-entry
// vectors plus hand-written multi-cycle sequences; issued instructions are
// checked against a scoreboard queue of expected results.
module tb_reservation_station;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [31:0] disp_instr, disp_pc, disp_imm;
  logic [4:0]  disp_rob_tag;
  logic [6:0]  disp_prd, disp_prs1, disp_prs2;
  logic        disp_rs1_ready, disp_rs2_ready;
  logic        cdb_valid;
  logic [6:0]  cdb_tag;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr, issue_pc, issue_imm;
  logic [4:0]  issue_rob_tag;
  logic [6:0]  issue_prd, issue_prs1, issue_prs2;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rob;
    logic [6:0]  p1;
    logic        r1;
    logic [6:0]  p2;
    logic        r2;
    logic        cv;
    logic [6:0]  ct;
    logic        exp_issue;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rob;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  reservation_station dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_instr     (disp_instr),
    .disp_pc        (disp_pc),
    .disp_imm       (disp_imm),
    .disp_rob_tag   (disp_rob_tag),
    .disp_prd       (disp_prd),
    .disp_prs1      (disp_prs1),
    .disp_prs2      (disp_prs2),
    .disp_rs1_ready (disp_rs1_ready),
    .disp_rs2_ready (disp_rs2_ready),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_instr    (issue_instr),
    .issue_pc       (issue_pc),
    .issue_imm      (issue_imm),
    .issue_rob_tag  (issue_rob_tag),
    .issue_prd      (issue_prd),
    .issue_prs1     (issue_prs1),
    .issue_prs2     (issue_prs2),
    .occupancy      (occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  function automatic logic [31:0] pc_of(input logic [31:0] instr);
    return instr ^ 32'h8000_0000;
  endfunction

  task automatic disp(input logic [31:0] instr, input logic [4:0] rob,
                      input logic [6:0] p1, input logic r1,
                      input logic [6:0] p2, input logic r2);
    disp_valid     = 1'b1;
    disp_instr     = instr;
    disp_pc        = pc_of(instr);
    disp_imm       = {27'd0, rob};
    disp_rob_tag   = rob;
    disp_prd       = {2'b10, rob};
    disp_prs1      = p1;
    disp_rs1_ready = r1;
    disp_prs2      = p2;
    disp_rs2_ready = r2;
  endtask

  task automatic cdb(input logic [6:0] t);
    cdb_valid = 1'b1;
    cdb_tag   = t;
  endtask

  task automatic push(input logic [31:0] instr, input logic [4:0] rob);
    exp_t e;
    e.instr = instr;
    e.pc    = pc_of(instr);
    e.rob   = rob;
    sb.push_back(e);
  endtask

  // Scoreboard: every accepted issue (valid && ready, sampled mid-cycle) must
  // match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && issue_valid && issue_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got rob_tag %0d expected no issue at %0t", issue_rob_tag, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rob_tag", 64'(issue_rob_tag), 64'(e.rob));
        check("sb_instr", 64'(issue_instr), 64'(e.instr));
        check("sb_pc", 64'(issue_pc), 64'(e.pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h00208133, 5'd3,  7'd5,  1'b1, 7'd6,  1'b1, 1'b0, 7'd0,  1'b1};
    vecs[1] = '{32'h00308193, 5'd4,  7'd9,  1'b0, 7'd6,  1'b1, 1'b0, 7'd0,  1'b0};
    vecs[2] = '{32'h00408213, 5'd5,  7'd9,  1'b0, 7'd6,  1'b1, 1'b1, 7'd9,  1'b1};
    vecs[3] = '{32'h00508293, 5'd6,  7'd5,  1'b1, 7'd12, 1'b0, 1'b1, 7'd12, 1'b1};
    vecs[4] = '{32'h00608313, 5'd7,  7'd20, 1'b0, 7'd21, 1'b0, 1'b1, 7'd20, 1'b0};
    vecs[5] = '{32'h00708393, 5'd8,  7'd30, 1'b0, 7'd30, 1'b0, 1'b1, 7'd30, 1'b1};
    vecs[6] = '{32'h00808413, 5'd9,  7'd5,  1'b1, 7'd12, 1'b0, 1'b0, 7'd12, 1'b0};
    vecs[7] = '{32'h00908493, 5'd10, 7'd7,  1'b0, 7'd6,  1'b1, 1'b1, 7'd8,  1'b0};

    reset = 1'b0;
    issue_ready = 1'b1;
    idle();
    disp(32'h0, 5'd0, 7'd0, 1'b0, 7'd0, 1'b0);
    disp_valid = 1'b0;
    cdb_tag = 7'd0;
    tick();
    tick();
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_instr", 64'(issue_instr), 64'h13);
    check("rst_issue_rob", 64'(issue_rob_tag), 64'd0);
    check("rst_disp_ready", 64'(disp_ready), 64'd1);
    reset = 1'b1;
    tick();

    // Table: one dispatch each, with and without wakeup bypass.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = vecs[i];
      disp(v.instr, v.rob, v.p1, v.r1, v.p2, v.r2);
      if (v.cv) cdb(v.ct);
      if (v.exp_issue) push(v.instr, v.rob);
      tick();
      idle();
      check("vec_occ_after_disp", 64'(occupancy), 64'd1);
      tick();
      check("vec_issue_valid", 64'(issue_valid), 64'(v.exp_issue));
      check("vec_occ_after_issue", 64'(occupancy), v.exp_issue ? 64'd0 : 64'd1);
      if (v.exp_issue) check("vec_issue_rob", 64'(issue_rob_tag), 64'(v.rob));
      tick();
      check("vec_issue_drop", 64'(issue_valid), 64'd0);
      if (!v.exp_issue) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("vec_occ_flushed", 64'(occupancy), 64'd0);
      end
    end

    // Younger ready instruction overtakes an older blocked one.
    disp(32'h00A00093, 5'd10, 7'd9, 1'b0, 7'd3, 1'b1);
    tick();
    disp(32'h00B00113, 5'd11, 7'd4, 1'b1, 7'd5, 1'b1);
    push(32'h00B00113, 5'd11);
    tick();
    idle();
    cdb(7'd9);
    push(32'h00A00093, 5'd10);
    tick();
    idle();
    check("ooo_first_valid", 64'(issue_valid), 64'd1);
    check("ooo_first_rob", 64'(issue_rob_tag), 64'd11);
    check("ooo_occ", 64'(occupancy), 64'd1);
    tick();
    check("ooo_second_rob", 64'(issue_rob_tag), 64'd10);
    check("ooo_occ_empty", 64'(occupancy), 64'd0);
    tick();
    check("ooo_drop", 64'(issue_valid), 64'd0);

    // Fill to capacity; a fifth dispatch must be refused.
    for (int k = 0; k < 4; k++) begin
      disp(32'h100 + 32'(k), 5'(20 + k), 7'(40 + k), 1'b0, 7'd2, 1'b1);
      tick();
    end
    idle();
    check("full_disp_ready", 64'(disp_ready), 64'd0);
    check("full_occ", 64'(occupancy), 64'd4);
    disp(32'hDEAD0013, 5'd25, 7'd1, 1'b1, 7'd2, 1'b1);
    cdb(7'd40);
    push(32'h100, 5'd20);
    tick();
    idle();
    check("full_occ_held", 64'(occupancy), 64'd4);
    check("full_still_blocked", 64'(disp_ready), 64'd0);
    tick();
    check("full_occ_freed", 64'(occupancy), 64'd3);
    check("full_disp_ready_back", 64'(disp_ready), 64'd1);
    check("full_issue_rob", 64'(issue_rob_tag), 64'd20);
    for (int k = 1; k < 4; k++) begin
      cdb(7'(40 + k));
      push(32'h100 + 32'(k), 5'(20 + k));
      tick();
    end
    idle();
    tick();
    tick();
    check("full_drained", 64'(occupancy), 64'd0);
    check("full_drained_valid", 64'(issue_valid), 64'd0);

    // Back-pressure: issue register holds for three cycles, then streams.
    issue_ready = 1'b0;
    disp(32'h200, 5'd1, 7'd1, 1'b1, 7'd2, 1'b1);
    push(32'h200, 5'd1);
    tick();
    disp(32'h201, 5'd2, 7'd1, 1'b1, 7'd2, 1'b1);
    push(32'h201, 5'd2);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", 64'(issue_valid), 64'd1);
      check("stall_rob", 64'(issue_rob_tag), 64'd1);
      check("stall_instr", 64'(issue_instr), 64'h200);
      check("stall_occ", 64'(occupancy), 64'd1);
      tick();
    end
    issue_ready = 1'b1;
    tick();
    check("stall_next_valid", 64'(issue_valid), 64'd1);
    check("stall_next_rob", 64'(issue_rob_tag), 64'd2);
    check("stall_next_occ", 64'(occupancy), 64'd0);
    tick();
    check("stall_drop", 64'(issue_valid), 64'd0);

    // Flush with a held issue register, three waiting entries, and a dispatch.
    issue_ready = 1'b0;
    disp(32'h300, 5'd5, 7'd1, 1'b1, 7'd2, 1'b1);
    tick();
    disp(32'h301, 5'd6, 7'd50, 1'b0, 7'd2, 1'b1);
    tick();
    disp(32'h302, 5'd7, 7'd51, 1'b0, 7'd2, 1'b1);
    tick();
    disp(32'h303, 5'd8, 7'd52, 1'b0, 7'd2, 1'b1);
    tick();
    idle();
    check("pre_flush_occ", 64'(occupancy), 64'd3);
    check("pre_flush_valid", 64'(issue_valid), 64'd1);
    flush = 1'b1;
    disp(32'h304, 5'd9, 7'd1, 1'b1, 7'd2, 1'b1);
    tick();
    idle();
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_issue_valid", 64'(issue_valid), 64'd0);
    check("flush_disp_ready", 64'(disp_ready), 64'd1);
    issue_ready = 1'b1;
    tick();
    tick();
    check("flush_dropped_valid", 64'(issue_valid), 64'd0);
    check("flush_dropped_occ", 64'(occupancy), 64'd0);

    // Asynchronous reset in the middle of a cycle.
    issue_ready = 1'b0;
    disp(32'h400, 5'd12, 7'd1, 1'b1, 7'd2, 1'b1);
    tick();
    disp(32'h401, 5'd13, 7'd60, 1'b0, 7'd2, 1'b1);
    tick();
    idle();
    check("pre_rst_valid", 64'(issue_valid), 64'd1);
    check("pre_rst_occ", 64'(occupancy), 64'd1);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 64'(issue_valid), 64'd0);
    check("async_rst_occ", 64'(occupancy), 64'd0);
    check("async_rst_instr", 64'(issue_instr), 64'h13);
    check("async_rst_rob", 64'(issue_rob_tag), 64'd0);
    check("async_rst_pc", 64'(issue_pc), 64'd0);
    check("async_rst_prd", 64'(issue_prd), 64'd0);
    check("async_rst_disp_ready", 64'(disp_ready), 64'd1);
    #1;
    reset = 1'b1;
    issue_ready = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 64'(issue_valid), 64'd0);
    check("post_rst_occ", 64'(occupancy), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Unified in-order-allocated, out-of-order-issue reservation station between `decode_DS` dispatch and the execute units. It accepts renamed instructions from dispatch, tracks readiness of each physical source operand, snoops the result broadcast bus for wakeups, and issues the oldest ready instruction through a registered valid/ready port. Compacting organisation: entry 0 is always the oldest.

## Interface
- `DEPTH`, 4: number of entries (≥2)
- `REG_FILE_ADDR_WIDTH`, 7: physical register tag width
- `ROB_ADDR_WIDTH`, 5: ROB tag width
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of all entries and the issue register (ROB rollback)
- `disp_valid`  in  1  dispatch offers an instruction
- `disp_ready`  out  1  station can accept this cycle
- `disp_instr`, `disp_pc`, `disp_imm`  in  32 each  instruction word, PC, decoded immediate
- `disp_rob_tag`  in  ROB_ADDR_WIDTH  allocated ROB slot
- `disp_prd`, `disp_prs1`, `disp_prs2`  in  REG_FILE_ADDR_WIDTH  renamed dest/sources
- `disp_rs1_ready`, `disp_rs2_ready`  in  1  source ready per map table
- `cdb_valid`  in  1  result broadcast valid
- `cdb_tag`  in  REG_FILE_ADDR_WIDTH  physical register being written
- `issue_valid`  out  1  issue register holds an instruction
- `issue_ready`  in  1  execute accepts the issue register
- `issue_instr`, `issue_pc`, `issue_imm`  out  32 each
- `issue_rob_tag`  out  ROB_ADDR_WIDTH
- `issue_prd`, `issue_prs1`, `issue_prs2`  out  REG_FILE_ADDR_WIDTH
- `occupancy`  out  $clog2(DEPTH+1)  valid entry count (excludes issue register)

## Operation
- Reset: all entries invalid, `occupancy`=0, `issue_valid`=0, all issue payload outputs 0, `issue_instr`=32'h00000013.
- `disp_ready` = `occupancy` < DEPTH, from registered state only; no same-cycle reuse of a slot freed by issue.
- Dispatch handshake: entry written at edge where `disp_valid && disp_ready`; placed at first free index after any compaction that edge.
- Wakeup: at each edge with `cdb_valid`, every valid entry whose `prs1`/`prs2` equals `cdb_tag` sets the matching ready bit.
- Dispatch/wakeup bypass: if `cdb_valid` and `cdb_tag` matches `disp_prs1`/`disp_prs2` in the accepting cycle, the new entry is written ready for that source.
- Select: combinational, lowest-index entry with both ready bits set. Selection uses registered ready bits only (wakeup affects select the next cycle).
- Issue register loads selected entry when `!issue_valid || issue_ready`; selected entry removed and entries above shift down one index that edge.
- `issue_valid` held, payload stable, until `issue_ready`; if `issue_ready` and nothing selected, `issue_valid` drops.
- `flush` priority over dispatch, wakeup and issue: at the edge, all entries invalid, `issue_valid`=0, `occupancy`=0.
- Simultaneous dispatch and issue: `occupancy` unchanged; new entry lands at index `occupancy`-1.
- Reset mid-operation: immediate clear to reset values regardless of clock.

## Timing
- Dispatch accepted at edge E0 with both sources ready: `issue_valid`=1 after E1 (one-cycle dispatch-to-issue).
- Source woken by CDB at edge Ew: earliest issue register load at Ew+1.
- Sustained throughput: one issue per cycle when `issue_ready` held high and ready entries exist.
- `occupancy` and `disp_ready` update at the edge, never combinationally from inputs.

## Structure
- Shared package `ooo_pkg`: `REG_FILE_ADDR_WIDTH`, `NOP_INSTR`, `rs_entry_t` packed struct (valid, instr, pc, imm, rob_tag, prd, prs1, rs1_ready, prs2, rs2_ready).
- Sub-module `rs_select`: parameterised lowest-index priority encoder over per-entry ready vector, outputs `found` and index.

## Test plan
- Reset then dispatch instr 32'h00208133, prs1=5 ready, prs2=6 ready, rob_tag=3 at E0 -> `issue_valid`=1 after E1 with `issue_rob_tag`=3, `occupancy` back to 0.
- Dispatch A (prs1=9 not ready) then B (both ready) -> B issues first; `cdb_valid`,`cdb_tag`=9 -> A issues the following cycle.
- Fill 4 entries all not ready -> `disp_ready`=0, `occupancy`=4; fifth `disp_valid` ignored; one wakeup+issue -> `disp_ready`=1 next cycle.
- Dispatch with prs2=12 not ready while `cdb_tag`=12 valid same cycle -> entry ready, issues one cycle later.
- `issue_ready`=0 for 3 cycles with two ready entries -> `issue_valid` and payload stable, `occupancy`=1; release -> second entry follows back-to-back.
- Three entries held, assert `flush` together with `disp_valid` -> after edge `occupancy`=0, `issue_valid`=0, dispatched instr dropped; assert `reset` low mid-cycle -> outputs clear immediately.
